// File: rtl/serial_paralelo_align.sv
// Single-lane deserializer: comma search, byte alignment lock, parallel output.
// Ports: clk_32f, reset (sync, low), data_serial -> data_paralelo, valid_out, byte_strobe, active.
module serial_paralelo_align #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_serial,
  output logic [7:0] data_paralelo,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ALIGN,
    ST_ACTIVE
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t      state;
  logic [7:0]  sr;
  logic [7:0]  nxt;
  logic [2:0]  bit_cnt;
  logic [3:0]  bc_cnt;
  logic        is_com;
  logic        boundary;

  // Byte ending at the bit being sampled this cycle.
  assign nxt      = {sr[6:0], data_serial};
  assign is_com   = (nxt == COM);
  assign boundary = (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state         <= ST_SEARCH;
      sr            <= 8'h00;
      bit_cnt       <= 3'd0;
      bc_cnt        <= 4'd0;
      data_paralelo <= 8'h00;
      valid_out     <= 1'b0;
      byte_strobe   <= 1'b0;
      active        <= 1'b0;
    end else begin
      sr          <= nxt;
      byte_strobe <= 1'b0;
      unique case (state)
        ST_SEARCH: begin
          // Any bit offset may start alignment.
          if (is_com) begin
            state   <= ST_ALIGN;
            bc_cnt  <= 4'd1;
            bit_cnt <= 3'd0;
          end
        end
        ST_ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_com) begin
              bc_cnt <= bc_cnt + 4'd1;
              if (bc_cnt + 4'd1 == LOCK_N) begin
                state  <= ST_ACTIVE;
                active <= 1'b1;
              end
            end else begin
              // Search restarts on the following cycle.
              state  <= ST_SEARCH;
              bc_cnt <= 4'd0;
            end
          end
        end
        ST_ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            data_paralelo <= nxt;
            valid_out     <= !is_com;
            byte_strobe   <= 1'b1;
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_align.sv
// Bench for serial_paralelo_align: directed plan plus random streams
// checked every cycle against a bit-history reference model.
module tb_serial_paralelo_align;

  localparam logic [7:0] COM  = 8'hBC;
  localparam int         LOCK = 4;

  logic       clk_32f = 1'b0;
  logic       reset = 1'b0;
  logic       data_serial = 1'b0;
  logic [7:0] data_paralelo;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int checks = 0;
  int passes = 0;

  serial_paralelo_align #(.COM(COM), .LOCK_COUNT(LOCK)) dut (
    .clk_32f      (clk_32f),
    .reset        (reset),
    .data_serial  (data_serial),
    .data_paralelo(data_paralelo),
    .valid_out    (valid_out),
    .byte_strobe  (byte_strobe),
    .active       (active)
  );

  always #5 clk_32f = ~clk_32f;

  // Reference model: bits since reset, and the bit index where
  // the current alignment candidate's first COM ended.
  bit         hist[$];
  int         t;
  int         anchor;
  int         run;
  bit         locked;
  logic [7:0] e_data;
  logic       e_valid;
  logic       e_strobe;
  logic       e_active;

  function automatic logic [7:0] last8();
    logic [7:0] v;
    int idx;
    v = 8'h00;
    for (int k = 0; k < 8; k++) begin
      idx = hist.size() - 8 + k;
      v = {v[6:0], (idx >= 0) ? logic'(hist[idx]) : 1'b0};
    end
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    t = 0;
    anchor = -1;
    run = 0;
    locked = 0;
    e_data = 8'h00;
    e_valid = 0;
    e_strobe = 0;
    e_active = 0;
  endtask

  task automatic model_step(input bit b);
    logic [7:0] by;
    hist.push_back(b);
    by = last8();
    e_strobe = 0;
    if (locked) begin
      if ((t - anchor) % 8 == 0) begin
        e_data = by;
        e_valid = (by != COM);
        e_strobe = 1;
      end
    end else if (anchor < 0) begin
      if (by == COM) begin
        anchor = t;
        run = 1;
      end
    end else if ((t - anchor) % 8 == 0) begin
      if (by == COM) begin
        run++;
        if (run == LOCK) begin
          locked = 1;
          e_active = 1;
        end
      end else begin
        anchor = -1;
      end
    end
    t++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_data"},   data_paralelo, e_data);
    chk({tag, "_valid"},  {7'd0, valid_out},   {7'd0, e_valid});
    chk({tag, "_strobe"}, {7'd0, byte_strobe}, {7'd0, e_strobe});
    chk({tag, "_active"}, {7'd0, active},      {7'd0, e_active});
  endtask

  // Called at posedge+1; drives the next bit well away from the edge.
  task automatic send_bit(input bit b);
    data_serial = b;
    @(posedge clk_32f);
    model_step(b);
    #1;
    chk_all("cyc");
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    data_serial = 1'($urandom);
    repeat (n) @(posedge clk_32f);
    model_reset();
    #1;
    chk_all("rst");
    chk("rst_zero_data", data_paralelo, 8'h00);
    reset = 1'b1;
  endtask

  initial begin
    int k;
    int pre;
    logic [7:0] r;

    // 1. Aligned lock and data
    do_reset(2);
    for (int i = 0; i < 31; i++) send_bit(COM[7 - (i % 8)]);
    chk("t1_pre_lock", {7'd0, active}, 8'd0);
    send_bit(COM[0]);
    chk("t1_lock", {7'd0, active}, 8'd1);
    send_byte(8'hFF);
    chk("t1_ff", data_paralelo, 8'hFF);
    chk("t1_ff_strobe", {7'd0, byte_strobe}, 8'd1);
    send_byte(8'hEE);
    chk("t1_ee", data_paralelo, 8'hEE);

    // 2. Misaligned start
    do_reset(1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (4) send_byte(COM);
    chk("t2_lock", {7'd0, active}, 8'd1);
    send_byte(8'h12);
    chk("t2_data", data_paralelo, 8'h12);
    chk("t2_valid", {7'd0, valid_out}, 8'd1);

    // 3. Broken alignment, then 4. COM while active
    do_reset(1);
    repeat (3) send_byte(COM);
    send_byte(8'h00);
    chk("t3_no_lock", {7'd0, active}, 8'd0);
    repeat (4) send_byte(COM);
    chk("t3_lock", {7'd0, active}, 8'd1);
    send_byte(8'h55);
    chk("t3_data", data_paralelo, 8'h55);
    send_byte(8'hA1);
    chk("t4_a1", {valid_out, data_paralelo[6:0]}, 8'hA1);
    send_byte(COM);
    chk("t4_com", data_paralelo, COM);
    chk("t4_com_valid", {7'd0, valid_out}, 8'd0);
    send_byte(8'hB2);
    chk("t4_b2", data_paralelo, 8'hB2);
    chk("t4_active", {7'd0, active}, 8'd1);

    // 5. Reset mid-stream
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    do_reset(1);
    chk("t5_active0", {7'd0, active}, 8'd0);
    repeat (3) send_byte(COM);
    send_byte(8'h77);
    chk("t5_no_lock", {7'd0, active}, 8'd0);
    repeat (4) send_byte(COM);
    send_byte(8'h77);
    chk("t5_data", data_paralelo, 8'h77);

    // 6. No comma
    do_reset(1);
    repeat (200) send_bit(1'b0);
    repeat (200) send_bit(1'b1);
    chk("t6_active", {7'd0, active}, 8'd0);

    // Random streams: random prefix, random COM run, random payload
    for (int it = 0; it < 25; it++) begin
      do_reset(1 + int'($urandom_range(0, 2)));
      pre = int'($urandom_range(0, 7));
      for (int i = 0; i < pre; i++) send_bit(1'($urandom));
      k = int'($urandom_range(2, 6));
      repeat (k) send_byte(COM);
      for (int i = 0; i < 8; i++) begin
        r = ($urandom_range(0, 4) == 0) ? COM : 8'($urandom);
        if (i == 3 && $urandom_range(0, 3) == 0) begin
          send_bit(1'($urandom));
          do_reset(1);
        end
        send_byte(r);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_align.md
# serial_paralelo_align

Single-lane receive deserializer with comma alignment for the PCI physical layer. It runs on the `clk_32f` serial clock and shifts in one bit per cycle from a lane (`data_paralelo_serial_*`). It locks byte alignment after `LOCK_COUNT` consecutive COM symbols (`8'hBC`), then presents each received byte in parallel with a valid flag. It feeds the RX lane-combining/demux stage, one instance per lane.

## Interface

Parameters:
- `COM` — default `8'hBC` — comma/idle symbol used for alignment.
- `LOCK_COUNT` — default `4` — consecutive aligned COM bytes required to go active; legal range 2..15.

Ports:
- `clk_32f` — input — 1 — serial bit clock. Single clock domain; all logic on the rising edge.
- `reset` — input — 1 — synchronous, active-low reset, sampled on the `clk_32f` rising edge.
- `data_serial` — input — 1 — serial lane bit, MSB of each byte first.
- `data_paralelo` — output — 8 — last deserialized byte, held for 8 cycles.
- `valid_out` — output — 1 — high when `data_paralelo` holds a non-COM byte received while active; held for 8 cycles.
- `byte_strobe` — output — 1 — one-cycle pulse marking each `data_paralelo` update while active.
- `active` — output — 1 — alignment locked. High from lock until reset.

## Operation

- Shift register `sr[7:0]`: on every non-reset cycle, `sr <= {sr[6:0], data_serial}`. `nxt = {sr[6:0], data_serial}` is the byte ending at the current bit.
- `bit_cnt[2:0]` is the index of the incoming bit within the current byte. A byte boundary occurs in a cycle with `bit_cnt == 7` while in ALIGN or ACTIVE.
- `bc_cnt` counts consecutive aligned COM bytes.
- **SEARCH** (reset state): compare `nxt` to `COM` every cycle, at any bit offset.
  - On match: go to ALIGN, set `bc_cnt = 1`, set `bit_cnt = 0`.
  - Otherwise: stay in SEARCH.
- **ALIGN**: `bit_cnt` increments mod 8 each cycle. At a boundary:
  - If `nxt == COM`: `bc_cnt++`. When the new count equals `LOCK_COUNT`, go to ACTIVE and set `active <= 1`.
  - If `nxt != COM`: return to SEARCH, `bc_cnt = 0`. No re-check of this same cycle for a new match; the search resumes next cycle.
- **ACTIVE**: `bit_cnt` keeps incrementing mod 8. At every boundary, in the same cycle:
  - `data_paralelo <= nxt`
  - `valid_out <= (nxt != COM)`
  - `byte_strobe <= 1`
  - In all other cycles, `byte_strobe <= 0` and `data_paralelo`/`valid_out` hold.
  - COM bytes received while active are passed through with `valid_out = 0`.
  - No loss-of-lock detection; only reset leaves ACTIVE.
- Reset (`reset == 0` at an edge), including mid-operation: next state is SEARCH; `sr`, `bit_cnt`, and `bc_cnt` clear to 0. All outputs become 0 after that edge: `data_paralelo = 8'h00`, `valid_out = 0`, `byte_strobe = 0`, `active = 0`.

## Timing

- All outputs are registered. No combinational path from `data_serial` to any output.
- Lock latency: `active` is high after the edge that samples the last bit of the `LOCK_COUNT`-th COM. For an aligned stream starting right after reset, that is 32 cycles for the default `LOCK_COUNT`.
- Data latency: `data_paralelo`, `valid_out`, and `byte_strobe` update on the edge that samples bit 0 (LSB, last bit) of the byte. Zero extra cycles after the byte completes.
- The first data byte after lock appears 8 cycles after `active` rises.
- `data_paralelo`/`valid_out` are stable for exactly 8 cycles between updates, so the downstream `clk_4f` logic can sample them safely.
- `byte_strobe` is high for 1 of every 8 cycles while active.
- `bit_cnt` wraps 7→0 without an idle cycle. Byte boundaries are exactly 8 cycles apart once aligned.

## Test plan

1. **Aligned lock and data.** Reset low 2 cycles, then serial `BC,BC,BC,BC,FF,EE`. Expect `active` to rise after bit 32. Then `data_paralelo = FF`, `valid_out = 1` for 8 cycles, followed by `EE`, `valid_out = 1`. `byte_strobe` pulses at bits 40 and 48.
2. **Misaligned start.** Bits `101`, then `BC×4`, then `12`. Expect lock at the offset-3 alignment, `active` high after bit 35, then `data_paralelo = 12`, `valid_out = 1`.
3. **Broken alignment.** `BC,BC,BC,00`, then `BC×4,55`. Expect `active` to stay 0 through the first attempt; the FSM returns to SEARCH at the `00` boundary. `active` rises after the second group, then `data_paralelo = 55`.
4. **COM while active.** After lock, send `A1,BC,B2`. Expect `data_paralelo` sequence `A1/1`, `BC/0`, `B2/1` (value/`valid_out`), with `active` remaining 1.
5. **Reset mid-stream.** After lock, assert `reset = 0` in the middle of a byte. Expect all outputs 0 on the next edge. Subsequent `BC×3,77` must not activate; `BC×4,77` then yields `data_paralelo = 77`.
6. **No comma.** 200 cycles of constant 0, then constant 1. Expect `active`, `valid_out`, and `byte_strobe` to stay 0 throughout.
